icache_refill: RTL and testbench

ICACHE_REFILL -- requirements
Module: icache_refill

---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_refill.sv | 177 +++++++++++++++++
 tb/tb_icache_refill.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared constants, refill state encoding and address helpers for the
// instruction-cache line refill engine.
package icache_pkg;

  localparam int LINE_WORDS = 8;
  localparam int INDEX_W    = 7;
  localparam int TAG_W      = 20;
  localparam int OFFSET_W   = 3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [7:0] AXI_LEN_LINE   = 8'(LINE_WORDS - 1);
  localparam logic [2:0] LAST_BEAT      = 3'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_RD   = 2'd2,
    ST_TAGW = 2'd3
  } refill_state_e;

  // Line-aligned address of the 32-byte line holding addr.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:5], 5'b0_0000};
  endfunction

endpackage

// File: rtl/icache_refill.sv
// I-cache miss refill: issues one 8-beat AXI INCR read for the missing line,
// streams beats into the data RAM, forwards the critical word, writes the tag.
module icache_refill
  import icache_pkg::*;
#(
  parameter logic [3:0] ARID = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lk_valid,
  input  logic [31:0] lk_addr,
  input  logic        lk_hit,
  input  logic        lk_tag_valid,
  input  logic        lk_work,
  output logic        busy,
  output logic        fwd_valid,
  output logic [31:0] fwd_data,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        tag_wen,
  output logic [INDEX_W-1:0]  tag_windex,
  output logic [TAG_W:0]      tag_wdata,
  output logic        data_wen,
  output logic [INDEX_W-1:0]  data_windex,
  output logic [OFFSET_W-1:0] data_woffset,
  output logic [31:0] data_wdata
);

  refill_state_e        state_r;
  refill_state_e        state_nxt_s;
  logic [31:0]          miss_addr_r;
  logic [OFFSET_W-1:0]  cnt_r;
  logic                 err_r;
  logic                 miss_s;
  logic                 start_s;
  logic                 ar_done_s;
  logic                 beat_s;
  logic                 beat_err_s;
  logic                 unused_s;

  assign miss_s     = lk_valid & lk_work & ~(lk_hit & lk_tag_valid);
  assign start_s    = (state_r == ST_IDLE) & miss_s;
  assign ar_done_s  = (state_r == ST_AR) & arready;
  assign beat_s     = (state_r == ST_RD) & rvalid;
  // A short burst (rlast before the eighth beat) leaves the line incomplete.
  assign beat_err_s = (rresp != 2'b00) | (rlast & (cnt_r != LAST_BEAT));
  assign arid       = ARID;
  assign unused_s   = ^miss_addr_r[1:0];

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (miss_s) state_nxt_s = ST_AR;
        else        state_nxt_s = ST_IDLE;
      end
      ST_AR: begin
        if (arready) state_nxt_s = ST_RD;
        else         state_nxt_s = ST_AR;
      end
      ST_RD: begin
        if (rvalid && rlast) state_nxt_s = ST_TAGW;
        else                 state_nxt_s = ST_RD;
      end
      ST_TAGW: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Miss address, beat counter and sticky error flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      miss_addr_r <= 32'h0000_0000;
      cnt_r       <= 3'd0;
      err_r       <= 1'b0;
    end else begin
      if (start_s) begin
        miss_addr_r <= lk_addr;
      end else begin
        miss_addr_r <= miss_addr_r;
      end

      if (ar_done_s) begin
        cnt_r <= 3'd0;
      end else if (beat_s) begin
        cnt_r <= cnt_r + 3'd1;
      end else begin
        cnt_r <= cnt_r;
      end

      if (start_s) begin
        err_r <= 1'b0;
      end else if (beat_s && beat_err_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Output decode; payloads are zero whenever their strobe is low
  always_comb begin
    busy         = 1'b0;
    arvalid      = 1'b0;
    araddr       = 32'h0000_0000;
    arlen        = 8'd0;
    arsize       = 3'd0;
    arburst      = 2'b00;
    rready       = 1'b0;
    data_wen     = 1'b0;
    data_windex  = 7'd0;
    data_woffset = 3'd0;
    data_wdata   = 32'h0000_0000;
    fwd_valid    = 1'b0;
    fwd_data     = 32'h0000_0000;
    tag_wen      = 1'b0;
    tag_windex   = 7'd0;
    tag_wdata    = 21'd0;
    case (state_r)
      ST_IDLE: busy = 1'b0;
      ST_AR: begin
        busy    = 1'b1;
        arvalid = 1'b1;
        araddr  = line_base(miss_addr_r);
        arlen   = AXI_LEN_LINE;
        arsize  = AXI_SIZE_4B;
        arburst = AXI_BURST_INCR;
      end
      ST_RD: begin
        busy   = 1'b1;
        rready = 1'b1;
        if (rvalid) begin
          data_wen     = 1'b1;
          data_windex  = miss_addr_r[11:5];
          data_woffset = cnt_r;
          data_wdata   = rdata;
          if (cnt_r == miss_addr_r[4:2]) begin
            fwd_valid = 1'b1;
            fwd_data  = rdata;
          end else begin
            fwd_valid = 1'b0;
          end
        end else begin
          data_wen = 1'b0;
        end
      end
      ST_TAGW: begin
        busy       = 1'b1;
        tag_wen    = 1'b1;
        tag_windex = miss_addr_r[11:5];
        tag_wdata  = {~err_r, miss_addr_r[31:12]};
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: lookup vector table, directed
// refill corner cases and randomized refills against an address-arithmetic model.
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        resetn;
  logic        lk_valid, lk_hit, lk_tag_valid, lk_work;
  logic [31:0] lk_addr;
  logic        busy, fwd_valid;
  logic [31:0] fwd_data;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        tag_wen;
  logic [6:0]  tag_windex;
  logic [20:0] tag_wdata;
  logic        data_wen;
  logic [6:0]  data_windex;
  logic [2:0]  data_woffset;
  logic [31:0] data_wdata;

  int checks = 0;
  int errors = 0;

  icache_refill dut (
    .clk(clk), .resetn(resetn),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_hit(lk_hit),
    .lk_tag_valid(lk_tag_valid), .lk_work(lk_work),
    .busy(busy), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .tag_wen(tag_wen), .tag_windex(tag_windex), .tag_wdata(tag_wdata),
    .data_wen(data_wen), .data_windex(data_windex), .data_woffset(data_woffset),
    .data_wdata(data_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain address arithmetic on a 32-byte, 128-set line.
  function automatic logic [31:0] m_base(input logic [31:0] a);
    return a - (a % 32);
  endfunction
  function automatic logic [31:0] m_index(input logic [31:0] a);
    return (a / 32) % 128;
  endfunction
  function automatic logic [31:0] m_crit(input logic [31:0] a);
    return (a % 32) / 4;
  endfunction
  function automatic logic [31:0] m_tagw(input logic [31:0] a, input bit err);
    return (err ? 32'd0 : 32'h0010_0000) + (a / 4096);
  endfunction

  task automatic lookup(input logic v, input logic hit, input logic tv, input logic work,
                        input logic [31:0] a, input logic exp_miss);
    lk_valid = v; lk_hit = hit; lk_tag_valid = tv; lk_work = work; lk_addr = a;
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_tag_wen", tag_wen, 1'b0);
    chk("idle_arvalid", arvalid, 1'b0);
    @(negedge clk);
    lk_valid = 1'b0; lk_hit = 1'b0; lk_tag_valid = 1'b0; lk_work = 1'b1;
    #1;
    chk("lookup_busy", busy, exp_miss);
    chk("lookup_arvalid", arvalid, exp_miss);
  endtask

  // Drives one refill from the AR cycle onward; stray lookups are injected while busy.
  task automatic refill(input logic [31:0] a, input int ar_wait, input int bad_beat,
                        input int last_beat, input int gap_pct, input logic [31:0] dbase,
                        input int abort_beat);
    bit exp_err;
    int k;
    int fwd_cnt;
    exp_err = (bad_beat >= 0 && bad_beat <= last_beat) || (last_beat != 7);
    for (int w = 0; w <= ar_wait; w++) begin
      arready = (w == ar_wait);
      lk_valid = 1'($urandom_range(0, 1)); lk_addr = $urandom;
      #1;
      chk("ar_busy", busy, 1'b1);
      chk("ar_arvalid", arvalid, 1'b1);
      chk("ar_araddr", araddr, m_base(a));
      chk("ar_arlen", arlen, 8'd7);
      chk("ar_arsize", arsize, 3'd2);
      chk("ar_arburst", arburst, 2'b01);
      chk("ar_arid", arid, 4'd0);
      chk("ar_rready", rready, 1'b0);
      chk("ar_data_wen", data_wen, 1'b0);
      @(negedge clk);
    end
    arready = 1'b0;
    k = 0;
    fwd_cnt = 0;
    for (int cyc = 0; cyc < 64 && k <= last_beat; cyc++) begin
      rvalid = (cyc >= 32 || $urandom_range(0, 99) >= gap_pct) ? 1'b1 : 1'b0;
      lk_valid = 1'($urandom_range(0, 1)); lk_addr = $urandom;
      if (rvalid) begin
        rdata = dbase + k; rlast = (k == last_beat); rresp = (k == bad_beat) ? 2'b10 : 2'b00;
      end else begin
        rdata = $urandom; rlast = 1'($urandom_range(0, 1)); rresp = 2'b11;
      end
      #1;
      chk("rd_rready", rready, 1'b1);
      chk("rd_arvalid", arvalid, 1'b0);
      chk("rd_busy", busy, 1'b1);
      chk("rd_data_wen", data_wen, rvalid);
      chk("rd_tag_wen", tag_wen, 1'b0);
      if (rvalid) begin
        chk("rd_woffset", data_woffset, k);
        chk("rd_windex", data_windex, m_index(a));
        chk("rd_wdata", data_wdata, dbase + k);
        chk("rd_fwd_valid", fwd_valid, (k == m_crit(a)));
        if (k == m_crit(a)) chk("rd_fwd_data", fwd_data, dbase + k);
        fwd_cnt += int'(fwd_valid);
      end else begin
        chk("gap_fwd_valid", fwd_valid, 1'b0);
      end
      if (rvalid && k == abort_beat) begin
        lk_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_data_wen", data_wen, 1'b0);
        chk("rst_fwd_valid", fwd_valid, 1'b0);
        chk("rst_tag_wen", tag_wen, 1'b0);
        @(negedge clk);
        chk("rst_hold_tag_wen", tag_wen, 1'b0);
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        resetn = 1'b1;
        #1;
        chk("rst_rel_busy", busy, 1'b0);
        @(negedge clk);
        chk("rst_rel_tag_wen", tag_wen, 1'b0);
        return;
      end
      if (rvalid) k++;
      @(negedge clk);
    end
    chk("rd_beats_done", k, last_beat + 1);
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    lk_valid = 1'($urandom_range(0, 1)); lk_addr = $urandom;
    #1;
    chk("tagw_tag_wen", tag_wen, 1'b1);
    chk("tagw_index", tag_windex, m_index(a));
    chk("tagw_wdata", tag_wdata, m_tagw(a, exp_err));
    chk("tagw_busy", busy, 1'b1);
    chk("tagw_rready", rready, 1'b0);
    chk("tagw_data_wen", data_wen, 1'b0);
    chk("fwd_count", fwd_cnt, (m_crit(a) <= last_beat) ? 1 : 0);
    @(negedge clk);
    lk_valid = 1'b0;
  endtask

  typedef struct {
    logic        v, hit, tv, work;
    logic [31:0] addr;
    logic        exp_miss;
  } lk_vec_t;

  lk_vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2004, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0FFC, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFE0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEC, 1'b0};

    resetn = 1'b0;
    lk_valid = 1'b0; lk_hit = 1'b0; lk_tag_valid = 1'b0; lk_work = 1'b0; lk_addr = 32'd0;
    arready = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_arvalid", arvalid, 1'b0);
    chk("reset_rready", rready, 1'b0);
    chk("reset_tag_wen", tag_wen, 1'b0);
    chk("reset_data_wen", data_wen, 1'b0);
    chk("reset_fwd_valid", fwd_valid, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      lookup(vecs[i].v, vecs[i].hit, vecs[i].tv, vecs[i].work, vecs[i].addr, vecs[i].exp_miss);
      if (vecs[i].exp_miss) refill(vecs[i].addr, 1, -1, 7, 20, 32'hC000_0000 + 32'(i * 16), -1);
    end

    // AR held off three cycles, gappy R channel, critical word is beat 1.
    lookup(1'b1, 1'b0, 1'b0, 1'b1, 32'h1FC0_0024, 1'b1);
    refill(32'h1FC0_0024, 3, -1, 7, 40, 32'h0000_00A0, -1);
    // Error on beat 3, then a miss in the cycle straight after TAGW clears it.
    lookup(1'b1, 1'b0, 1'b0, 1'b1, 32'h1FC0_0024, 1'b1);
    refill(32'h1FC0_0024, 0, 3, 7, 0, 32'h0000_00B0, -1);
    lookup(1'b1, 1'b0, 1'b0, 1'b1, 32'h1FC0_0024, 1'b1);
    refill(32'h1FC0_0024, 0, -1, 7, 30, 32'h0000_00C0, -1);
    // Burst ending early on beat 3 marks the line invalid.
    lookup(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 1'b1);
    refill(32'h0000_4000, 0, -1, 3, 0, 32'h0000_0D00, -1);
    // Reset during beat 4, then a full refill after release.
    lookup(1'b1, 1'b0, 1'b0, 1'b1, 32'h1FC0_0024, 1'b1);
    refill(32'h1FC0_0024, 1, -1, 7, 0, 32'h0000_00E0, 4);
    lookup(1'b1, 1'b0, 1'b0, 1'b1, 32'h1FC0_0024, 1'b1);
    refill(32'h1FC0_0024, 0, -1, 7, 25, 32'h0000_00F0, -1);

    for (int n = 0; n < 40; n++) begin
      logic v, h, t, w, m;
      logic [31:0] a;
      int bad;
      v = 1'($urandom_range(0, 3) != 0);
      h = 1'($urandom_range(0, 1));
      t = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 4) != 0);
      a = $urandom;
      m = v & w & ~(h & t);
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      lookup(v, h, t, w, a, m);
      if (m) refill(a, int'($urandom_range(0, 3)), bad, 7, int'($urandom_range(0, 50)), $urandom, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
